// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receiver, transmitter and RX FIFO.
package uart_pkg;

   localparam int unsigned UART_DATA_W        = 8;
   localparam int unsigned UART_RX_FIFO_DEPTH = 16;
   // 100 MHz system clock, 115200 baud
   localparam int unsigned CLKS_PER_BIT       = 868;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver with sticky overflow.
// Define UART_RX_FIFO_HWM_EN to add the HIGH_WATER parameter and almost_full output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = UART_DATA_W,
   parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH
`ifdef UART_RX_FIFO_HWM_EN
  ,parameter int unsigned HIGH_WATER = DEPTH - 4
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx_valid,
   input  logic [DATA_W-1:0]          rx_byte,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_byte,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   input  logic                       ovf_clr
`ifdef UART_RX_FIFO_HWM_EN
  ,output logic                       almost_full
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              push_c,   pop_c;

   // Flags decode straight from the registered count
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign out_valid = !empty;
   assign count     = count_q;
   assign overflow  = ovf_q;

   assign pop_c  = out_valid && out_ready;
   assign push_c = rx_valid && (!full || pop_c);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (push_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear keeps the flag set
      if (ovf_clr)                       ovf_d = 1'b0;
      if (rx_valid && full && !pop_c)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef UART_RX_FIFO_HWM_EN
   logic af_q;

   // Registered from next_count so it lines up with count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (count_d >= CNT_W'(HIGH_WATER));
      end
   end

   assign almost_full = af_q;
`endif

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_c),
      .waddr (wr_ptr_q),
      .wdata (rx_byte),
      .raddr (rd_ptr_q),
      .rdata (out_byte)
   );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor checks pops.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx_valid = 1'b0;
   uart_byte_t rx_byte = '0;
   logic       out_valid;
   uart_byte_t out_byte;
   logic       out_ready = 1'b0;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_HWM_EN
   logic       almost_full;
`endif

   int tests = 0;
   int fails = 0;
   uart_byte_t exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DATA_W     (8),
      .DEPTH      (16)
`ifdef UART_RX_FIFO_HWM_EN
     ,.HIGH_WATER (12)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .out_valid   (out_valid),
      .out_byte    (out_byte),
      .out_ready   (out_ready),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_HWM_EN
     ,.almost_full (almost_full)
`endif
   );

   // Monitor: every accepted handshake must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pop_unexpected: got %02h, nothing expected", out_byte);
         end else begin
            uart_byte_t e;
            e = exp_q.pop_front();
            if (out_byte !== e) begin
               fails++;
               $display("FAIL pop_data: got %02h, expected %02h", out_byte, e);
            end
         end
      end
`ifdef UART_RX_FIFO_HWM_EN
      if (rst_n) begin
         tests++;
         if (almost_full !== (count >= 5'd12)) begin
            fails++;
            $display("FAIL almost_full: got %0b with count %0d, expected %0b",
                     almost_full, count, (count >= 5'd12));
         end
      end
`endif
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while (!empty && n < 40) begin
         tick();
         n++;
      end
      out_ready = 1'b0;
      check(name, 32'(empty), 32'd1);
   endtask

   initial begin
      int mcount;
      int sent;
      logic rv, orr, pu, po;

      // Reset
      #2 rst_n = 1'b0;
      #10;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_empty",     32'(empty),     32'd1);
      check("rst_full",      32'(full),      32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single byte, one-cycle latency
      rx_valid = 1'b1; rx_byte = 8'h41; exp_q.push_back(8'h41);
      tick();
      rx_valid = 1'b0;
      check("one_out_valid", 32'(out_valid), 32'd1);
      check("one_out_byte",  32'(out_byte),  32'h41);
      check("one_count",     32'(count),     32'd1);
      check("one_empty",     32'(empty),     32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("one_pop_empty", 32'(empty), 32'd1);
      check("one_pop_count", 32'(count), 32'd0);

      // Fill to full
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_byte = 8'(i); exp_q.push_back(8'(i));
         tick();
      end
      rx_valid = 1'b0;
      check("fill_full",  32'(full),  32'd1);
      check("fill_count", 32'(count), 32'd16);

      // Drop while full
      rx_valid = 1'b1; rx_byte = 8'hAA;
      tick();
      rx_valid = 1'b0;
      check("drop_overflow", 32'(overflow), 32'd1);
      check("drop_count",    32'(count),    32'd16);

      // Drop together with clear: flag stays set
      rx_valid = 1'b1; rx_byte = 8'hBB; ovf_clr = 1'b1;
      tick();
      rx_valid = 1'b0; ovf_clr = 1'b0;
      check("setwins_overflow", 32'(overflow), 32'd1);

      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("clr_overflow", 32'(overflow), 32'd0);
      check("hold_head",    32'(out_byte), 32'h00);
      check("hold_count",   32'(count),    32'd16);

      // Full with simultaneous push and pop
      rx_valid = 1'b1; rx_byte = 8'h55; out_ready = 1'b1; exp_q.push_back(8'h55);
      tick();
      rx_valid = 1'b0; out_ready = 1'b0;
      check("fullpp_count",    32'(count),    32'd16);
      check("fullpp_full",     32'(full),     32'd1);
      check("fullpp_overflow", 32'(overflow), 32'd0);
      check("fullpp_head",     32'(out_byte), 32'h01);
      drain("drain1_empty");

      // Empty with ready high: push still lands, no pop on the empty cycle
      out_ready = 1'b1; rx_valid = 1'b1; rx_byte = 8'h77; exp_q.push_back(8'h77);
      tick();
      rx_valid = 1'b0;
      check("emptyrdy_count", 32'(count), 32'd1);
      tick();
      out_ready = 1'b0;
      check("emptyrdy_drained", 32'(count), 32'd0);

      // Streaming wrap-around with ready toggling every cycle
      mcount = 0;
      sent = 0;
      for (int i = 0; i < 60; i++) begin
         rv  = (i % 3 != 2) && (sent < 40);
         orr = (i % 2 == 1);
         rx_valid  = rv;
         rx_byte   = 8'(8'h80 + sent);
         out_ready = orr;
         po = (mcount > 0) && orr;
         pu = rv && ((mcount < 16) || po);
         if (pu) begin
            exp_q.push_back(rx_byte);
            sent++;
         end
         mcount = mcount + int'(pu) - int'(po);
         tick();
         check("stream_count", 32'(count), 32'(mcount));
      end
      rx_valid = 1'b0; out_ready = 1'b0;
      check("stream_sent",     32'(sent),     32'd40);
      check("stream_overflow", 32'(overflow), 32'd0);
      drain("drain2_empty");

      // Async reset mid-stream at count 7 with overflow set
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1'b1; rx_byte = 8'(8'hC0 + i); exp_q.push_back(8'(8'hC0 + i));
         tick();
      end
      rx_byte = 8'hEE;
      tick();
      rx_valid = 1'b0;
      check("pre_rst_overflow", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      out_ready = 1'b0;
      check("pre_rst_count", 32'(count),    32'd7);
      check("pre_rst_head",  32'(out_byte), 32'hC9);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_count",     32'(count),     32'd0);
      check("arst_overflow",  32'(overflow),  32'd0);
`ifdef UART_RX_FIFO_HWM_EN
      check("arst_almost_full", 32'(almost_full), 32'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_empty", 32'(empty), 32'd1);
      check("scoreboard_left", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_rx_fifo
